// File: rtl/oai_gw_pipe.sv
// Registered, scan-testable OR-AND-INVERT macro: GROUPS groups of WIDTH inputs,
// an optional C term, an input capture register and an optional output stage.
module oai_gw_pipe #(
   parameter int GROUPS = 2,
   parameter int WIDTH  = 2,
   parameter int USE_C  = 1,
   parameter int STAGES = 1
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      EN,
   input  logic                      VLD_I,
   input  logic [GROUPS*WIDTH-1:0]   A,
   input  logic                      C,
   input  logic                      SE,
   input  logic                      SI,
   output logic                      ZN,
   output logic                      VLD_O,
   output logic                      SO
);

   localparam int N = GROUPS * WIDTH;

   generate
      if (GROUPS < 1 || GROUPS > 8 || WIDTH < 1 || WIDTH > 8 ||
          (USE_C != 0 && USE_C != 1) ||
          (STAGES != 1 && STAGES != 2)) begin : g_bad_param
         $error("oai_gw_pipe: illegal parameter value");
      end
   endgenerate

   logic [N:0]        ir_q, ir_d;
   logic              vr_q, vr_d;
   logic [GROUPS-1:0] grp_or;
   logic              c_term;
   logic              f_zn;

   // Scan shift has priority over functional capture
   always_comb begin
      ir_d = ir_q;
      vr_d = vr_q;
      if (SE) begin
         ir_d = {ir_q[N-1:0], SI};
         vr_d = 1'b0;
      end else if (EN) begin
         ir_d = {A, C};
         vr_d = VLD_I;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ir_q <= '0;
         vr_q <= 1'b0;
      end else begin
         ir_q <= ir_d;
         vr_q <= vr_d;
      end
   end

   genvar g;
   generate
      for (g = 0; g < GROUPS; g++) begin : g_or
         assign grp_or[g] = |ir_q[g*WIDTH+1 +: WIDTH];
      end
   endgenerate

   assign c_term = (USE_C != 0) ? ir_q[0] : 1'b1;
   assign f_zn   = ~(&grp_or & c_term);
   assign SO     = ir_q[N];

   generate
      if (STAGES == 2) begin : g_out_reg
         logic zr_q, zr_d;
         logic vz_q, vz_d;

         always_comb begin
            zr_d = zr_q;
            vz_d = vz_q;
            if (!SE && EN) begin
               zr_d = f_zn;
               vz_d = vr_q;
            end
         end

         // ZR resets to 1 so ZN matches f(0) whatever the depth
         always_ff @(posedge CLK) begin
            if (RST) begin
               zr_q <= 1'b1;
               vz_q <= 1'b0;
            end else begin
               zr_q <= zr_d;
               vz_q <= vz_d;
            end
         end

         assign ZN    = zr_q;
         assign VLD_O = vz_q;
      end else begin : g_comb_out
         assign ZN    = f_zn;
         assign VLD_O = vr_q;
      end
   endgenerate

endmodule

// File: tb/tb_oai_gw_pipe.sv
// Scoreboard bench for oai_gw_pipe: three builds (2x2 one/two stages,
// 3x4 without C) sharing control inputs.
module tb_oai_gw_pipe;

   logic        clk = 1'b0;
   logic        rst, en, vi, se, si, c;
   logic [3:0]  a4;
   logic [11:0] a12;
   logic        zn0, vld0, so0;
   logic        zn1, vld1, so1;
   logic        zn2, vld2, so2;

   int errs   = 0;
   int checks = 0;
   logic adv  = 1'b0;

   logic q0[$];
   logic q1[$];
   logic q2[$];

   always #5 clk = ~clk;

   oai_gw_pipe #(.GROUPS(2), .WIDTH(2), .USE_C(1), .STAGES(2)) u0 (
      .CLK(clk), .RST(rst), .EN(en), .VLD_I(vi), .A(a4), .C(c),
      .SE(se), .SI(si), .ZN(zn0), .VLD_O(vld0), .SO(so0));

   oai_gw_pipe #(.GROUPS(2), .WIDTH(2), .USE_C(1), .STAGES(1)) u1 (
      .CLK(clk), .RST(rst), .EN(en), .VLD_I(vi), .A(a4), .C(c),
      .SE(se), .SI(si), .ZN(zn1), .VLD_O(vld1), .SO(so1));

   oai_gw_pipe #(.GROUPS(3), .WIDTH(4), .USE_C(0), .STAGES(2)) u2 (
      .CLK(clk), .RST(rst), .EN(en), .VLD_I(vi), .A(a12), .C(c),
      .SE(se), .SI(si), .ZN(zn2), .VLD_O(vld2), .SO(so2));

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic f4(input logic [3:0] a, input logic cv);
      return ~((a[0] | a[1]) & (a[2] | a[3]) & cv);
   endfunction

   function automatic logic f12(input logic [11:0] b);
      return ~((|b[3:0]) & (|b[7:4]) & (|b[11:8]));
   endfunction

   // Outputs only advance on functional EN edges
   always @(posedge clk) adv <= en && !se && !rst;

   always @(negedge clk) begin
      if (adv) begin
         if (vld0) begin
            chk("q0_avail", q0.size() != 0, 1);
            if (q0.size() != 0) chk("zn0", zn0, q0.pop_front());
         end
         if (vld1) begin
            chk("q1_avail", q1.size() != 0, 1);
            if (q1.size() != 0) chk("zn1", zn1, q1.pop_front());
         end
         if (vld2) begin
            chk("q2_avail", q2.size() != 0, 1);
            if (q2.size() != 0) chk("zn2", zn2, q2.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      q0.delete();
      q1.delete();
      q2.delete();
   endtask

   task automatic cap(input logic [3:0] a, input logic cv,
                      input logic [11:0] b);
      a4  = a;
      c   = cv;
      a12 = b;
      en  = 1'b1;
      vi  = 1'b1;
      se  = 1'b0;
      q0.push_back(f4(a, cv));
      q1.push_back(f4(a, cv));
      q2.push_back(f12(b));
      tick();
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_zn0"}, zn0, 1);
      chk({tag, "_v0"}, vld0, 0);
      chk({tag, "_so0"}, so0, 0);
      chk({tag, "_zn1"}, zn1, 1);
      chk({tag, "_v1"}, vld1, 0);
      chk({tag, "_so1"}, so1, 0);
      chk({tag, "_zn2"}, zn2, 1);
      chk({tag, "_v2"}, vld2, 0);
      chk({tag, "_so2"}, so2, 0);
   endtask

   initial begin
      logic [4:0]  pat;
      logic [11:0] b;

      rst = 1'b1; en = 1'b1; vi = 1'b1; se = 1'b0; si = 1'b0;
      a4 = 4'hF; c = 1'b1; a12 = 12'hFFF;
      tick();
      tick();
      chk_rst("rst");

      rst = 1'b0;
      cap(4'hF, 1'b1, 12'hFFF);
      chk("lat2_v0", vld0, 0);
      chk("lat1_v1", vld1, 1);

      // Full sweep; first two captures carry the 3x4 width cases
      for (int i = 0; i < 32; i++) begin
         logic [4:0] iv;
         iv = i[4:0];
         if (i == 0)      b = 12'h111;
         else if (i == 1) b = 12'h011;
         else             b = 12'($urandom);
         cap(iv[3:0], iv[4], b);
         chk("sweep_v1", vld1, 1);
      end

      cap(4'b0101, 1'b1, 12'h111);
      cap(4'b0101, 1'b1, 12'h111);
      chk("hold_pre", zn0, 0);
      en = 1'b0; vi = 1'b0; a4 = 4'h0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_zn0", zn0, 0);
         chk("hold_v0", vld0, 1);
      end
      cap(4'h0, 1'b1, 12'h111);
      chk("pulse1_zn0", zn0, 0);
      chk("pulse1_v0", vld0, 1);
      cap(4'h0, 1'b1, 12'h111);
      chk("pulse2_zn0", zn0, 1);

      cap(4'b0101, 1'b1, 12'h111);
      chk("se_pre_v1", vld1, 1);
      se = 1'b1;
      tick();
      chk("se_v1", vld1, 0);
      rst = 1'b1; en = 1'b1;
      tick();
      chk_rst("rst_se_en");
      rst = 1'b0; se = 1'b0; en = 1'b0;
      flush();

      // Scan 1,0,1,1,0 into a cleared chain; SO lags SI by four edges
      pat = 5'b10110;
      se = 1'b1;
      for (int k = 0; k < 5; k++) begin
         si = pat[4-k];
         tick();
         chk("scan_so1", so1, (k == 4) ? 1 : 0);
         chk("scan_so0", so0, (k == 4) ? 1 : 0);
         chk("scan_so2", so2, 0);
      end
      se = 1'b0; en = 1'b0;
      tick();
      chk("scan_zn1", zn1, f4(4'b1011, 1'b0));
      chk("scan_v1", vld1, 0);
      se = 1'b1; si = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("scan_tail", so1, pat[3-k]);
      end
      se = 1'b0;

      cap(4'b0101, 1'b1, 12'h111);
      chk("vz_clr_v0", vld0, 0);
      chk("vz_clr_v2", vld2, 0);
      cap(4'b0011, 1'b1, 12'h011);
      chk("post_v0", vld0, 1);
      chk("post_zn0", zn0, 0);
      cap(4'b1111, 1'b0, 12'h111);
      chk("post_zn1", zn1, 1);
      en = 1'b0;
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
